// File: rtl/motor_pkg.sv
// Shared types and default widths for the motor command sequencer.
// State encoding is fixed because it is exported on o_state.
package motor_pkg;

    localparam int K_PWMRES_DEF   = 10;
    localparam int K_SPDWIDTH_DEF = 15;
    localparam int K_BRAKE_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        RAMP_DOWN = 2'd2,
        BRAKE     = 2'd3
    } t_cmd_seq_state;

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp prescaler: o_tick pulses once every i_period+1 clocks.
// A period shrunk below the running count wraps immediately instead of stalling.
module ramp_tick_gen (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_period,
    output logic       o_tick
);

    logic [7:0] prescaler_q;
    logic [7:0] prescaler_d;

    always_comb begin
        o_tick      = (prescaler_q >= i_period);
        prescaler_d = o_tick ? 8'd0 : prescaler_q + 8'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) prescaler_q <= 8'd0;
        else          prescaler_q <= prescaler_d;
    end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Shapes a raw duty/direction/stop target into PWM command, reverse and brake
// outputs: slew-limited ramping, ramp-down plus braking before a reversal.
module motor_cmd_sequencer
    import motor_pkg::*;
#(
    parameter int K_PWMRES   = K_PWMRES_DEF,
    parameter int K_SPDWIDTH = K_SPDWIDTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [K_PWMRES-1:0]   i_target_cmd,
    input  logic                  i_target_reverse,
    input  logic                  i_stop_req,
    input  logic                  i_estop,
    input  logic [K_SPDWIDTH-1:0] i_speed,
    input  logic                  i_speed_valid,
    input  logic [K_PWMRES-1:0]   i_param_pwm_max,
    input  logic [K_PWMRES-1:0]   i_param_ramp_step,
    input  logic [7:0]            i_param_ramp_period,
    input  logic [7:0]            i_param_brake_min,
    input  logic [K_SPDWIDTH-1:0] i_param_low_speed_thr,
    output logic [K_PWMRES-1:0]   o_pwm_command,
    output logic                  o_reverse,
    output logic                  o_brake,
    output logic                  o_busy,
    output logic [1:0]            o_state
);

    t_cmd_seq_state            state_q, state_d;
    logic [K_PWMRES-1:0]       cmd_q, cmd_d;
    logic                      dir_q, dir_d;
    logic [K_BRAKE_CNT_W-1:0]  brake_cnt_q, brake_cnt_d;
    logic                      speed_low_q, speed_low_d;
    logic                      tick;
    logic [K_PWMRES-1:0]       eff_target;

    ramp_tick_gen u_tick (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_period (i_param_ramp_period),
        .o_tick   (tick)
    );

    // One slew step toward x; the extra bit keeps cur+step and cur-step from wrapping.
    function automatic logic [K_PWMRES-1:0] ramp_toward(
        input logic [K_PWMRES-1:0] cur,
        input logic [K_PWMRES-1:0] x,
        input logic [K_PWMRES-1:0] step
    );
        logic [K_PWMRES:0]   up;
        logic [K_PWMRES:0]   dn;
        logic [K_PWMRES-1:0] res;
        up  = {1'b0, cur} + {1'b0, step};
        dn  = {1'b0, cur} - {1'b0, step};
        res = cur;
        if (step == '0) begin
            res = x;
        end else if (cur < x) begin
            res = (up > {1'b0, x}) ? x : up[K_PWMRES-1:0];
        end else if (cur > x) begin
            res = (dn[K_PWMRES] || (dn[K_PWMRES-1:0] < x)) ? x : dn[K_PWMRES-1:0];
        end
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        dir_d       = dir_q;
        brake_cnt_d = brake_cnt_q;
        speed_low_d = i_speed_valid ? (i_speed < i_param_low_speed_thr) : speed_low_q;
        eff_target  = (i_target_cmd < i_param_pwm_max) ? i_target_cmd : i_param_pwm_max;

        if (i_estop) begin
            state_d     = BRAKE;
            cmd_d       = '0;
            brake_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cmd_d = '0;
                    if (!i_stop_req) begin
                        dir_d   = i_target_reverse;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick) cmd_d = ramp_toward(cmd_q, eff_target, i_param_ramp_step);
                    if (i_stop_req || (i_target_reverse != dir_q)) state_d = RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    if (tick) cmd_d = ramp_toward(cmd_q, '0, i_param_ramp_step);
                    if (!i_stop_req && (i_target_reverse == dir_q)) begin
                        state_d = RUN;
                    end else if (cmd_q == '0) begin
                        state_d     = BRAKE;
                        brake_cnt_d = '0;
                    end
                end
                BRAKE: begin
                    cmd_d = '0;
                    if (tick && (brake_cnt_q != '1)) brake_cnt_d = brake_cnt_q + 1'b1;
                    // Exit judged on registered speed_low, so a same-cycle strobe counts next cycle.
                    if (speed_low_q && (brake_cnt_q >= i_param_brake_min)) begin
                        if (i_stop_req) begin
                            state_d = IDLE;
                        end else begin
                            dir_d   = i_target_reverse;
                            state_d = RUN;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            dir_q       <= 1'b0;
            brake_cnt_q <= '0;
            speed_low_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            dir_q       <= dir_d;
            brake_cnt_q <= brake_cnt_d;
            speed_low_q <= speed_low_d;
        end
    end

    assign o_pwm_command = cmd_q;
    assign o_reverse     = dir_q;
    assign o_brake       = (state_q == BRAKE);
    assign o_busy        = (state_q == RAMP_DOWN) || (state_q == BRAKE);
    assign o_state       = state_q;

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed scenarios plus a random phase, all
// compared cycle by cycle against a behavioural model of the command rules.
module tb_motor_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  target_cmd = '0;
    logic        target_reverse = 1'b0;
    logic        stop_req = 1'b1;
    logic        estop = 1'b0;
    logic [14:0] speed = '0;
    logic        speed_valid = 1'b0;
    logic [9:0]  pwm_max = 10'd1023;
    logic [9:0]  ramp_step = 10'd100;
    logic [7:0]  ramp_period = 8'd3;
    logic [7:0]  brake_min = 8'd5;
    logic [14:0] low_thr = 15'd2640;

    logic [9:0]  dut_cmd;
    logic        dut_rev;
    logic        dut_brake;
    logic        dut_busy;
    logic [1:0]  dut_state;

    int n_checks = 0;
    int n_fails  = 0;

    // model: state numbers are the exported o_state values
    int m_st, m_cmd, m_dir, m_cnt, m_presc, m_slow;
    bit brake_seen;

    motor_cmd_sequencer dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_target_cmd          (target_cmd),
        .i_target_reverse      (target_reverse),
        .i_stop_req            (stop_req),
        .i_estop               (estop),
        .i_speed               (speed),
        .i_speed_valid         (speed_valid),
        .i_param_pwm_max       (pwm_max),
        .i_param_ramp_step     (ramp_step),
        .i_param_ramp_period   (ramp_period),
        .i_param_brake_min     (brake_min),
        .i_param_low_speed_thr (low_thr),
        .o_pwm_command         (dut_cmd),
        .o_reverse             (dut_rev),
        .o_brake               (dut_brake),
        .o_busy                (dut_busy),
        .o_state               (dut_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int slew(input int cur, input int goal, input int step);
        int nxt;
        if (step == 0) return goal;
        if (cur < goal) begin
            nxt = cur + step;
            return (nxt > goal) ? goal : nxt;
        end
        nxt = cur - step;
        return (nxt < goal) ? goal : nxt;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cmd = 0; m_dir = 0; m_cnt = 0; m_presc = 0; m_slow = 1;
    endtask

    task automatic model_step();
        bit tick;
        int goal, n_st, n_cmd, n_dir, n_cnt, n_slow;
        tick  = (m_presc == int'(ramp_period));
        goal  = (target_cmd < pwm_max) ? int'(target_cmd) : int'(pwm_max);
        n_st = m_st; n_cmd = m_cmd; n_dir = m_dir; n_cnt = m_cnt;
        n_slow = speed_valid ? int'(speed < low_thr) : m_slow;
        if (estop) begin
            n_st = 3; n_cmd = 0; n_cnt = 0;
        end else if (m_st == 0) begin
            n_cmd = 0;
            if (!stop_req) begin n_dir = target_reverse; n_st = 1; end
        end else if (m_st == 1) begin
            if (tick) n_cmd = slew(m_cmd, goal, ramp_step);
            if (stop_req || target_reverse != m_dir) n_st = 2;
        end else if (m_st == 2) begin
            if (tick) n_cmd = slew(m_cmd, 0, ramp_step);
            if (!stop_req && target_reverse == m_dir) n_st = 1;
            else if (m_cmd == 0) begin n_st = 3; n_cnt = 0; end
        end else begin
            n_cmd = 0;
            if (tick && m_cnt < 255) n_cnt = m_cnt + 1;
            if (m_slow != 0 && m_cnt >= brake_min) begin
                if (stop_req) n_st = 0;
                else begin n_dir = target_reverse; n_st = 1; end
            end
        end
        m_presc = tick ? 0 : m_presc + 1;
        m_st = n_st; m_cmd = n_cmd; m_dir = n_dir; m_cnt = n_cnt; m_slow = n_slow;
    endtask

    task automatic compare_all();
        check("cmd",     int'(dut_cmd),   m_cmd);
        check("state",   int'(dut_state), m_st);
        check("reverse", int'(dut_rev),   m_dir);
        check("brake",   int'(dut_brake), int'(m_st == 3));
        check("busy",    int'(dut_busy),  int'(m_st >= 2));
        if (dut_brake) brake_seen = 1'b1;
    endtask

    // one clock: model follows the edge, outputs compared on the falling edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        speed_valid = 1'b0;
    endtask

    task automatic strobe_speed(input int v);
        speed = 15'(v);
        speed_valid = 1'b1;
        cyc();
    endtask

    task automatic apply_reset(input int period);
        @(negedge clk);
        rst_n = 1'b0;
        ramp_period = 8'(period);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int prev;
        model_reset();
        brake_seen = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_cmd",   int'(dut_cmd),   0);
        check("reset_state", int'(dut_state), 0);
        check("reset_brake", int'(dut_brake), 0);
        check("reset_busy",  int'(dut_busy),  0);
        rst_n = 1'b1;
        repeat (3) cyc();
        check("idle_hold", int'(dut_state), 0);

        // ramp up to 1000 in exact steps of 100
        target_cmd = 10'd1000;
        stop_req = 1'b0;
        prev = 0;
        for (int i = 0; i < 200 && dut_cmd != 10'd1000; i++) begin
            cyc();
            if (int'(dut_cmd) != prev) begin
                check("ramp_up_step", int'(dut_cmd) - prev, 100);
                prev = int'(dut_cmd);
            end
        end
        check("ramp_up_final", int'(dut_cmd), 1000);
        target_cmd = 10'd250;
        repeat (40) cyc();
        check("ramp_down_250", int'(dut_cmd), 250);

        // direction change with braking gated on speed
        target_cmd = 10'd500;
        repeat (30) cyc();
        check("run_500", int'(dut_cmd), 500);
        strobe_speed(3000);
        target_reverse = 1'b1;
        for (int i = 0; i < 100 && dut_state != 2'd3; i++) cyc();
        check("dir_brake_entry", int'(dut_brake), 1);
        repeat (40) cyc();
        check("dir_brake_hold_fast", int'(dut_state), 3);
        strobe_speed(100);
        for (int i = 0; i < 50 && dut_state != 2'd1; i++) cyc();
        check("dir_run_again", int'(dut_state), 1);
        check("dir_reversed", int'(dut_rev), 1);

        // stop request withdrawn during ramp-down
        target_cmd = 10'd1000;
        for (int i = 0; i < 200 && dut_cmd != 10'd1000; i++) cyc();
        brake_seen = 1'b0;
        stop_req = 1'b1;
        for (int i = 0; i < 200 && dut_cmd != 10'd300; i++) cyc();
        check("abort_at_300", int'(dut_cmd), 300);
        stop_req = 1'b0;
        for (int i = 0; i < 200 && dut_cmd != 10'd1000; i++) cyc();
        check("abort_back_1000", int'(dut_cmd), 1000);
        check("abort_no_brake", int'(brake_seen), 0);

        // emergency stop mid tick period
        target_cmd = 10'd800;
        for (int i = 0; i < 100 && dut_cmd != 10'd800; i++) cyc();
        cyc();
        estop = 1'b1;
        cyc();
        check("estop_cmd0", int'(dut_cmd), 0);
        check("estop_brake", int'(dut_brake), 1);
        strobe_speed(50);
        repeat (30) cyc();
        check("estop_hold", int'(dut_state), 3);
        estop = 1'b0;
        stop_req = 1'b1;
        for (int i = 0; i < 60 && dut_state != 2'd0; i++) cyc();
        check("estop_to_idle", int'(dut_state), 0);

        // boundaries: zero step, duty ceiling, oversized step
        ramp_step = 10'd0;
        target_cmd = 10'd700;
        stop_req = 1'b0;
        for (int i = 0; i < 20 && dut_cmd == 10'd0; i++) cyc();
        check("step0_jump", int'(dut_cmd), 700);
        ramp_step = 10'd100;
        target_cmd = 10'd1023;
        pwm_max = 10'd600;
        repeat (30) cyc();
        check("pwm_max_sat", int'(dut_cmd), 600);
        ramp_step = 10'd700;
        stop_req = 1'b1;
        for (int i = 0; i < 20 && dut_cmd == 10'd600; i++) cyc();
        check("big_step_floor", int'(dut_cmd), 0);
        for (int i = 0; i < 20 && dut_state != 2'd3; i++) cyc();
        check("big_step_brake", int'(dut_state), 3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_brake_cmd",   int'(dut_cmd),   0);
        check("rst_brake_state", int'(dut_state), 0);
        check("rst_brake_brake", int'(dut_brake), 0);
        check("rst_brake_busy",  int'(dut_busy),  0);
        check("rst_brake_rev",   int'(dut_rev),   0);
        model_reset();

        // random phase
        for (int seg = 0; seg < 4; seg++) begin
            apply_reset($urandom_range(0, 4));
            ramp_step = 10'($urandom_range(0, 400));
            pwm_max   = 10'($urandom_range(200, 1023));
            brake_min = 8'($urandom_range(0, 8));
            stop_req  = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                target_cmd = 10'($urandom_range(0, 1023));
                if ($urandom_range(0, 79) == 0) target_reverse = ~target_reverse;
                if ($urandom_range(0, 99) == 0) stop_req = ~stop_req;
                if (!estop && $urandom_range(0, 399) == 0) estop = 1'b1;
                else if (estop && $urandom_range(0, 9) == 0) estop = 1'b0;
                if ($urandom_range(0, 199) == 0) ramp_step = 10'($urandom_range(0, 400));
                if ($urandom_range(0, 199) == 0) pwm_max = 10'($urandom_range(0, 1023));
                if ($urandom_range(0, 199) == 0) brake_min = 8'($urandom_range(0, 8));
                if ($urandom_range(0, 7) == 0) begin
                    speed = 15'($urandom_range(0, 5000));
                    speed_valid = 1'b1;
                end
                cyc();
            end
            estop = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
